// File: rtl/io_rx_controller_if.sv
// Image SRAM port bundle: row/column address, write data and the two strobes.
// The master drives every signal; the SRAM model only observes them.
interface img_sram_intf;
  logic [7:0] row;
  logic [7:0] col;
  logic [7:0] din;
  logic       write_en;
  logic       sense_en;

  modport mst (output row, output col, output din, output write_en, output sense_en);
  modport slv (input row, input col, input din, input write_en, input sense_en);
endinterface

// File: rtl/io_rx_controller.sv
// Byte-stream receiver that fills the image SRAM in row-major order.
// Dimensions are latched at start; done pulses once the final byte is committed.
module io_rx_controller (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       nrows,
  input  logic [7:0]       ncols,
  input  logic             abort,
  input  logic [7:0]       din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg,
  img_sram_intf.mst        sram_img
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] rows_q, rows_d;
  logic [7:0] cols_q, cols_d;
  logic [8:0] row_idx_q, row_idx_d;
  logic [8:0] col_idx_q, col_idx_d;
  logic [7:0] wr_row_q, wr_row_d;
  logic [7:0] wr_col_q, wr_col_d;
  logic [7:0] wr_din_q, wr_din_d;
  logic       write_en_q, write_en_d;
  logic       done_q, done_d;
  logic       last_col;
  logic       last_row;

  // Handshake: a byte transfers on every rising edge where din_valid && din_ready.
  // din_ready depends only on the state register, never on din_valid.
  assign din_ready = (state_q == ST_RECV);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign state_dbg = state_q;

  assign sram_img.row      = wr_row_q;
  assign sram_img.col      = wr_col_q;
  assign sram_img.din      = wr_din_q;
  assign sram_img.write_en = write_en_q;
  assign sram_img.sense_en = 1'b1;

  assign last_col = (col_idx_q == ({1'b0, cols_q} - 9'd1));
  assign last_row = (row_idx_q == ({1'b0, rows_q} - 9'd1));

  always_comb begin
    state_d    = state_q;
    rows_d     = rows_q;
    cols_d     = cols_q;
    row_idx_d  = row_idx_q;
    col_idx_d  = col_idx_q;
    wr_row_d   = wr_row_q;
    wr_col_d   = wr_col_q;
    wr_din_d   = wr_din_q;
    write_en_d = 1'b0;
    done_d     = 1'b0;

    // Abort wins over everything in the frame, including a same-edge accept.
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            rows_d    = nrows;
            cols_d    = ncols;
            row_idx_d = 9'd0;
            col_idx_d = 9'd0;
            if ((nrows == 8'd0) || (ncols == 8'd0)) begin
              done_d = 1'b1;
            end else begin
              state_d = ST_RECV;
            end
          end
        end
        ST_RECV: begin
          if (din_valid) begin
            write_en_d = 1'b1;
            wr_din_d   = din;
            wr_row_d   = row_idx_q[7:0];
            wr_col_d   = col_idx_q[7:0];
            if (last_col) begin
              col_idx_d = 9'd0;
              row_idx_d = row_idx_q + 9'd1;
              if (last_row) begin
                state_d = ST_FLUSH;
              end
            end else begin
              col_idx_d = col_idx_q + 9'd1;
            end
          end
        end
        ST_FLUSH: begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rows_q     <= 8'd0;
      cols_q     <= 8'd0;
      row_idx_q  <= 9'd0;
      col_idx_q  <= 9'd0;
      wr_row_q   <= 8'd0;
      wr_col_q   <= 8'd0;
      wr_din_q   <= 8'd0;
      write_en_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rows_q     <= rows_d;
      cols_q     <= cols_d;
      row_idx_q  <= row_idx_d;
      col_idx_q  <= col_idx_d;
      wr_row_q   <= wr_row_d;
      wr_col_q   <= wr_col_d;
      wr_din_q   <= wr_din_d;
      write_en_q <= write_en_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_io_rx_controller.sv
// Directed bench for io_rx_controller: every SRAM write is matched against an
// expected {row, col, data} queue; cycle-exact control outputs are checked inline.
module tb_io_rx_controller;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] nrows;
  logic [7:0] ncols;
  logic       abort;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       busy;
  logic       done;
  logic [1:0] state_dbg;

  img_sram_intf sram_if ();

  io_rx_controller dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .nrows     (nrows),
    .ncols     (ncols),
    .abort     (abort),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg),
    .sram_img  (sram_if)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int wr_cnt = 0;
  int base;
  logic [23:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every write cycle must match the oldest expected write.
  always @(negedge clk) begin
    if (sram_if.write_en === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {8'd0, sram_if.row, sram_if.col, sram_if.din}, 32'hFFFF_FFFF);
      end else begin
        chk("sram_write", {8'd0, sram_if.row, sram_if.col, sram_if.din}, {8'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; nrows = 8'd0; ncols = 8'd0;
    abort = 1'b0; din = 8'd0; din_valid = 1'b0;
    tick(); tick();

    // Reset values
    chk("rst_ready", din_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", sram_if.write_en, 0);
    chk("rst_row", sram_if.row, 0);
    chk("rst_col", sram_if.col, 0);
    chk("rst_din", sram_if.din, 0);
    chk("rst_sense", sram_if.sense_en, 1);
    chk("rst_state", state_dbg, 0);
    rst = 1'b0;
    tick();

    // 2x3 frame, continuous valid
    base = wr_cnt;
    start = 1'b1; nrows = 8'd2; ncols = 8'd3;
    tick();
    start = 1'b0;
    chk("f23_ready", din_ready, 1);
    chk("f23_busy", busy, 1);
    din_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      din = 8'(8'h10 + i);
      exp_q.push_back({8'(i / 3), 8'(i % 3), 8'(8'h10 + i)});
      tick();
    end
    din_valid = 1'b0;
    chk("f23_flush_we", sram_if.write_en, 1);
    chk("f23_flush_ready", din_ready, 0);
    chk("f23_flush_busy", busy, 1);
    chk("f23_flush_done", done, 0);
    chk("f23_flush_state", state_dbg, 2);
    tick();
    chk("f23_done", done, 1);
    chk("f23_done_busy", busy, 0);
    chk("f23_done_we", sram_if.write_en, 0);
    tick();
    chk("f23_done_pulse", done, 0);
    chk("f23_count", wr_cnt - base, 6);
    chk("f23_q_empty", exp_q.size(), 0);

    // 3x3 frame, valid pattern 1,0,0
    base = wr_cnt;
    start = 1'b1; nrows = 8'd3; ncols = 8'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      din_valid = 1'b1;
      din = 8'(8'h30 + i);
      exp_q.push_back({8'(i / 3), 8'(i % 3), 8'(8'h30 + i)});
      tick();
      din_valid = 1'b0;
      chk("f33_we_after_accept", sram_if.write_en, 1);
      tick();
      chk("f33_gap1_we", sram_if.write_en, 0);
      chk("f33_gap_ready", din_ready, 1);
      tick();
      chk("f33_gap2_we", sram_if.write_en, 0);
    end
    din_valid = 1'b1;
    din = 8'h38;
    exp_q.push_back({8'd2, 8'd2, 8'h38});
    tick();
    din_valid = 1'b0;
    chk("f33_last_we", sram_if.write_en, 1);
    chk("f33_last_state", state_dbg, 2);
    tick();
    chk("f33_done", done, 1);
    tick();
    chk("f33_count", wr_cnt - base, 9);
    chk("f33_q_empty", exp_q.size(), 0);

    // Zero-dimension start
    base = wr_cnt;
    start = 1'b1; nrows = 8'd0; ncols = 8'd5;
    tick();
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_ready", din_ready, 0);
    tick();
    chk("zero_done_pulse", done, 0);
    chk("zero_busy2", busy, 0);
    chk("zero_count", wr_cnt - base, 0);

    // Abort with the 4th accepted byte of a 4x4 frame
    base = wr_cnt;
    start = 1'b1; nrows = 8'd4; ncols = 8'd4;
    tick();
    start = 1'b0;
    din_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = 8'(8'h50 + i);
      exp_q.push_back({8'd0, 8'(i), 8'(8'h50 + i)});
      tick();
    end
    din = 8'h53;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    din_valid = 1'b0;
    chk("abort_we", sram_if.write_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_state", state_dbg, 0);
    chk("abort_done", done, 0);
    tick();
    chk("abort_no_done", done, 0);
    chk("abort_count", wr_cnt - base, 3);
    chk("abort_q_empty", exp_q.size(), 0);

    // 1x1 frame after abort
    base = wr_cnt;
    start = 1'b1; nrows = 8'd1; ncols = 8'd1;
    tick();
    start = 1'b0;
    din_valid = 1'b1;
    din = 8'hAA;
    exp_q.push_back({8'd0, 8'd0, 8'hAA});
    tick();
    din_valid = 1'b0;
    chk("f11_we", sram_if.write_en, 1);
    chk("f11_ready", din_ready, 0);
    chk("f11_busy", busy, 1);
    tick();
    chk("f11_done", done, 1);
    tick();
    chk("f11_count", wr_cnt - base, 1);

    // Start while busy is ignored: 2x2 frame still ends after 4 bytes
    base = wr_cnt;
    start = 1'b1; nrows = 8'd2; ncols = 8'd2;
    tick();
    start = 1'b0;
    din_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        start = 1'b1; nrows = 8'd5; ncols = 8'd5;
      end else begin
        start = 1'b0;
      end
      din = 8'(8'h60 + i);
      exp_q.push_back({8'(i / 2), 8'(i % 2), 8'(8'h60 + i)});
      tick();
    end
    start = 1'b0;
    din_valid = 1'b0;
    chk("busy_start_flush", state_dbg, 2);
    tick();
    chk("busy_start_done", done, 1);
    tick();
    chk("busy_start_count", wr_cnt - base, 4);

    // Reset mid-frame
    base = wr_cnt;
    start = 1'b1; nrows = 8'd3; ncols = 8'd3;
    tick();
    start = 1'b0;
    din_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      din = 8'(8'h70 + i);
      exp_q.push_back({8'd0, 8'(i), 8'(8'h70 + i)});
      tick();
    end
    din = 8'h72;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    din_valid = 1'b0;
    chk("mid_rst_state", state_dbg, 0);
    chk("mid_rst_ready", din_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_we", sram_if.write_en, 0);
    chk("mid_rst_rowcol", {sram_if.row, sram_if.col, sram_if.din}, 0);
    tick();
    chk("mid_rst_count", wr_cnt - base, 2);
    chk("mid_rst_q_empty", exp_q.size(), 0);

    // 255x255 frame
    base = wr_cnt;
    start = 1'b1; nrows = 8'd255; ncols = 8'd255;
    tick();
    start = 1'b0;
    din_valid = 1'b1;
    for (int i = 0; i < 65025; i++) begin
      din = 8'(i);
      exp_q.push_back({8'(i / 255), 8'(i % 255), 8'(i)});
      tick();
    end
    din_valid = 1'b0;
    chk("big_last_we", sram_if.write_en, 1);
    chk("big_last_row", sram_if.row, 254);
    chk("big_last_col", sram_if.col, 254);
    chk("big_flush", state_dbg, 2);
    tick();
    chk("big_done", done, 1);
    tick();
    chk("big_count", wr_cnt - base, 65025);
    chk("big_q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/io_rx_controller.md
# io_rx_controller

Receives a raster image as a byte stream and writes it into the image SRAM in row-major order, one byte per accepted transfer. It sits directly upstream of the SRAM readout path: the host/IO side fills `sram_img` through this block, then the transmit controller reads the image back out. Image dimensions are latched at start. A one-cycle `done` pulse marks that the final byte has been committed to SRAM.

## Interface
- No parameters. Data width is 8 bits; row and column indices are 8 bits.
- `clk`  in  1  sole clock; `sram_img` is clocked from the same net.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a frame; ignored unless IDLE.
- `nrows`  in  8  image height in rows (1..255); sampled on accepted `start`.
- `ncols`  in  8  image width in columns (1..255); sampled on accepted `start`.
- `abort`  in  1  synchronous cancel; returns to IDLE with no further writes.
- `din`  in  8  stream byte.
- `din_valid`  in  1  `din` holds a valid byte.
- `din_ready`  out  1  block accepts a byte this cycle.
- `busy`  out  1  frame in progress (RECV or FLUSH).
- `done`  out  1  one-cycle pulse: frame completely written.
- `sram_img`  `img_sram_intf.mst`  master port; drives `row`, `col`, `din`, `write_en`, `sense_en`.

## Operation
- States: IDLE, RECV, FLUSH.
- IDLE, `start`=1:
  - Latch `nrows`/`ncols` into `rows_q`/`cols_q` and clear `row_idx`/`col_idx`.
  - If either dimension is 0: stay in IDLE, pulse `done` next cycle, issue no writes.
  - Otherwise: enter RECV.
- RECV: a transfer occurs on each edge where `din_valid && din_ready`. At that edge:
  - Register `din`→`sram_img.din`, `row_idx`→`sram_img.row`, `col_idx`→`sram_img.col`, and set `write_en`<=1.
  - Advance the indices: `col_idx`+1; when `col_idx`==`cols_q`-1, `col_idx`<=0 and `row_idx`+1.
  - If `row_idx`==`rows_q`-1 and `col_idx`==`cols_q`-1 (last byte): go to FLUSH.
- Edge in RECV with no transfer: `write_en`<=0; indices hold.
- FLUSH: the last write is in progress. Next edge: `write_en`<=0, `done`<=1, go to IDLE.
- `din_ready` = (state==RECV); decoded from the state register, no combinational path from `din_valid`.
- `busy` = (state!=IDLE).
- `sram_img.sense_en` held at its inactive level (1) at all times; this block never reads.
- `abort`, in any state: next edge → IDLE. `write_en`<=0; a byte accepted on the same edge is not written. `done` is not pulsed.
- `start` while busy is ignored; dimensions are not re-latched.
- `rst` dominates `abort` and `start`.
- Index counters are 9 bits internally; the SRAM gets the low 8 bits. Writes never exceed (`rows_q`-1, `cols_q`-1).

## Timing
- Reset values: state=IDLE, `din_ready`=0, `busy`=0, `done`=0, `write_en`=0, `sram_img.row`=0, `sram_img.col`=0, `sram_img.din`=0, indices 0.
- `start` sampled at edge k: `din_ready`=1 during cycle k+1.
- Byte accepted at edge t: `write_en`=1 during cycle t+1, with matching row/col/data. Write latency is 1 cycle.
- Full throughput: one byte per cycle while `din_valid` stays high.
- Last byte accepted at edge t:
  - Cycle t+1: FLUSH, `write_en`=1, `din_ready`=0, `busy`=1.
  - Cycle t+2: IDLE, `done`=1, `busy`=0, `write_en`=0.
- A new `start` is accepted in the same cycle `done`=1.
- Minimum frame (1×1) with `din_valid` held high: `start`@k, accept@k+1, write cycle k+2, `done` cycle k+3.
- Zero-dimension `start`@k: `done` cycle k+1, `busy` never asserted.

## Test plan
- 2×3 frame, bytes 0x10..0x15, `din_valid` constant → writes (0,0)=0x10, (0,1)=0x11, (0,2)=0x12, (1,0)=0x13, (1,1)=0x14, (1,2)=0x15 on consecutive cycles. `done` 2 cycles after the last accept. Exactly 6 `write_en` cycles.
- 3×3 frame with `din_valid` toggling 1,0,0,1,... → `write_en` only the cycle after each accept. Indices hold during gaps. Final write at (2,2).
- `nrows`=0, `ncols`=5 → `done` the cycle after `start`. `busy`=0 and `write_en`=0 throughout.
- `abort` asserted together with the 4th accepted byte of a 4×4 frame → only 3 writes ((0,0)..(0,2)). IDLE next cycle. No `done`. A following 1×1 frame completes normally.
- `rst` mid-frame and a second `start` while busy → all outputs return to their reset values. The second `start` is ignored: dimensions unchanged, write count matches the original frame.
- 255×255 frame → last write at (254,254). 65025 writes total. No index wrap.
